// File: rtl/maze_bfs_solver.sv
// maze_bfs_solver
//   Breadth-first maze solver. A (N+2)x(N+2) wall bitmap is loaded serially,
//   searched from (1,1) to (N,N) with a FIFO queue, and the shortest path is
//   streamed start-to-goal. An unsolvable maze produces one fail beat instead.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid, maze   serial maze bits, row-major from (0,0); 1 = wall
//   out_valid        path beat or fail beat
//   maze_not_valid   set on the fail beat
//   out_x, out_y     path cell in full-grid coordinates (0 on fail beat)
//   out_last         final beat (goal cell or fail beat)
module maze_bfs_solver #(
    parameter int N      = 13,
    parameter int CW     = $clog2(N + 2),
    parameter int QDEPTH = N * N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          maze,
    output logic          out_valid,
    output logic          maze_not_valid,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_last
);
    localparam int G    = N + 2;
    localparam int GG   = G * G;
    localparam int IW   = $clog2(GG);
    localparam int QW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNTW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] EDGE = CW'(G - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LIM  = CW'(N);

    typedef enum logic [2:0] {LOAD, CHECK, BFS, TRACE, EMIT, FAIL} state_t;

    state_t state, state_next;

    logic [GG-1:0]   wall, visited;
    logic [1:0]      par   [GG];      // direction of the move that discovered the cell
    logic [2*CW-1:0] queue [QDEPTH];
    logic [2*CW-1:0] stack [QDEPTH];
    logic [QW-1:0]   head, tail;
    logic [CNTW-1:0] qcnt, sp;
    logic [CW-1:0]   lx, ly, cx, cy, tx, ty;
    logic [2:0]      nb;              // 0..3 neighbour under test, 4 = dequeue phase

    logic [CW-1:0]   nx, ny, hx, hy, px, py;
    logic [IW-1:0]   n_idx, t_idx, l_idx;
    logic [QW-1:0]   sp_wr, sp_rd;
    logic            accept, border, load_done, start_bad, n_open, push, at_goal, trace_done;
    logic            beat_valid, beat_fail, beat_last;
    logic [CW-1:0]   beat_x, beat_y;

    function automatic logic [IW-1:0] idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return IW'(y) * IW'(G) + IW'(x);
    endfunction

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign {hx, hy} = queue[head];

    always_comb begin
        nx = cx;
        ny = cy;
        case (nb)
            3'd0:    nx = cx - ONE;   // LEFT
            3'd1:    ny = cy - ONE;   // UP
            3'd2:    nx = cx + ONE;   // RIGHT
            3'd3:    ny = cy + ONE;   // DOWN
            default: ;
        endcase
        // Undo the discovering move to step back towards the start.
        px = tx;
        py = ty;
        case (par[t_idx])
            2'd0:    px = tx + ONE;
            2'd1:    py = ty + ONE;
            2'd2:    px = tx - ONE;
            default: py = ty - ONE;
        endcase
    end

    assign n_idx      = idx(nx, ny);
    assign t_idx      = idx(tx, ty);
    assign l_idx      = idx(lx, ly);
    assign sp_wr      = QW'(sp);
    assign sp_rd      = QW'(sp - CNTW'(1));
    // out_last high means this is the closing beat of the previous job.
    assign accept     = (state == LOAD) && in_valid && !out_last;
    assign border     = (lx == '0) || (lx == EDGE) || (ly == '0) || (ly == EDGE);
    assign load_done  = accept && (lx == EDGE) && (ly == EDGE);
    assign start_bad  = wall[idx(ONE, ONE)] | wall[idx(LIM, LIM)];
    assign n_open     = !wall[n_idx] && !visited[n_idx];
    assign push       = (state == BFS) && !nb[2] && n_open;
    assign at_goal    = (hx == LIM) && (hy == LIM);
    assign trace_done = (tx == ONE) && (ty == ONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            LOAD:  if (load_done) state_next = CHECK;
            CHECK: state_next = start_bad ? FAIL : BFS;
            BFS: begin
                if (nb[2]) begin
                    if (qcnt == '0)  state_next = FAIL;
                    else if (at_goal) state_next = TRACE;
                end
            end
            TRACE: if (trace_done) state_next = EMIT;
            EMIT:  if (sp == CNTW'(1)) state_next = LOAD;
            FAIL:  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Output logic: the fail beat is registered on entry to FAIL so it shows
    // during the FAIL cycle; path beats are registered from the stack top.
    always_comb begin
        beat_valid = 1'b0;
        beat_fail  = 1'b0;
        beat_last  = 1'b0;
        beat_x     = '0;
        beat_y     = '0;
        if (state == EMIT) begin
            beat_valid       = 1'b1;
            {beat_x, beat_y} = stack[sp_rd];
            beat_last        = (sp == CNTW'(1));
        end else if (state_next == FAIL) begin
            beat_valid = 1'b1;
            beat_fail  = 1'b1;
            beat_last  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            maze_not_valid <= 1'b0;
            out_last       <= 1'b0;
            out_x          <= '0;
            out_y          <= '0;
        end else begin
            out_valid      <= beat_valid;
            maze_not_valid <= beat_fail;
            out_last       <= beat_last;
            out_x          <= beat_x;
            out_y          <= beat_y;
        end
    end

    // Control datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx <= '0; ly <= '0; cx <= '0; cy <= '0; tx <= '0; ty <= '0;
            head <= '0; tail <= '0; qcnt <= '0; sp <= '0;
            nb <= 3'd4;
            visited <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (lx == EDGE) begin
                            lx <= '0;
                            ly <= (ly == EDGE) ? '0 : ly + ONE;
                        end else begin
                            lx <= lx + ONE;
                        end
                    end
                end
                CHECK: begin
                    if (!start_bad) begin
                        visited[idx(ONE, ONE)] <= 1'b1;
                        tail <= qinc(tail);
                        qcnt <= CNTW'(1);
                    end
                    nb <= 3'd4;
                end
                BFS: begin
                    if (nb[2]) begin
                        if (qcnt != '0) begin
                            cx   <= hx;
                            cy   <= hy;
                            tx   <= hx;
                            ty   <= hy;
                            head <= qinc(head);
                            qcnt <= qcnt - CNTW'(1);
                            nb   <= 3'd0;
                        end
                    end else begin
                        if (push) begin
                            visited[n_idx] <= 1'b1;
                            tail <= qinc(tail);
                            qcnt <= qcnt + CNTW'(1);
                        end
                        nb <= nb + 3'd1;
                    end
                end
                TRACE: begin
                    sp <= sp + CNTW'(1);
                    if (!trace_done) begin
                        tx <= px;
                        ty <= py;
                    end
                end
                EMIT: sp <= sp - CNTW'(1);
                default: ;
            endcase
            // Leaving a job: wipe search state before the next maze arrives.
            if (state != LOAD && state_next == LOAD) begin
                visited <= '0;
                head <= '0; tail <= '0; qcnt <= '0; sp <= '0;
                lx <= '0; ly <= '0;
            end
        end
    end

    // Storage arrays (contents are qualified by the reset-cleared pointers)
    always_ff @(posedge clk) begin
        if (accept) wall[l_idx] <= border | maze;
        if (state == CHECK) queue[tail] <= {ONE, ONE};
        if (push) begin
            queue[tail] <= {nx, ny};
            par[n_idx]  <= nb[1:0];
        end
        if (state == TRACE) stack[sp_wr] <= {tx, ty};
    end
endmodule
